xbar_out_queue: RTL

Output-side buffering stage placed directly downstream of the one-output crossbar. It accepts the crossbar's send_msg/send_val/send_rdy stream and holds up to DEPTH messages in a circular buffer. It re-presents them in order on a val/rdy port toward the output channel. Its recv_rdy is a function of registered state only, so the crossbar's recv_rdy path is cut and never depends combinationally on the downstream consumer.

---
 rtl/xbar_out_queue.sv | 47 ++++
 1 files changed

// File: rtl/xbar_out_queue.sv
// xbar_out_queue: circular-buffer FIFO after the crossbar; recv_rdy comes only from registered count,
// so the crossbar's ready path never sees the downstream consumer combinationally.
module xbar_out_queue #(
   parameter int BIT_WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] recv_msg,
   input  logic                 recv_val,
   output logic                 recv_rdy,
   output logic [BIT_WIDTH-1:0] send_msg,
   output logic                 send_val,
   input  logic                 send_rdy,
   output logic [CNT_W-1:0]     num_free
);
   logic [BIT_WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic enq, deq;
   always_comb begin
      recv_rdy = count != CNT_W'(DEPTH);
      send_val = count != '0;
      send_msg = storage[head];
      num_free = CNT_W'(DEPTH) - count;
      enq = recv_val && recv_rdy;
      deq = send_val && send_rdy;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + 1'b1;
         if (deq) head <= head + 1'b1;
         if (enq && !deq) count <= count + 1'b1;
         else if (deq && !enq) count <= count - 1'b1;
      end
   end
   // storage carries no reset; only the pointers define what is valid
   always_ff @(posedge clk) begin
      if (!reset && enq) storage[tail] <= recv_msg;
   end
endmodule
